// File: rtl/mole_spawner.sv
// -----------------------------------------------------------------------------
// mole_spawner
//
// Round generator for a whack-a-mole game. An 18-bit LFSR picks one or two
// mole positions per round. Moles stay raised until every one is hit (early
// clear) or until MOLE_LIFE game ticks elapse (expiry). On expiry, the moles
// still standing are added to a saturating miss counter. The game ends when
// the miss count reaches MAX_MISSES.
//
// Parameters
//   TICK_DIV   : clk cycles per game tick (>= 2)
//   MOLE_LIFE  : ticks a round's moles stay up (1..15)
//   MAX_MISSES : miss count that ends the game (1..15)
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : begins a game from IDLE or OVER (ignored while playing)
//   hit_reg    : per-position hit strobe from the whack logic
//   moles      : currently raised moles
//   misses     : moles that expired unhit this game, saturating at 15
//   round_cnt  : completed rounds this game, wraps 255 -> 0
//   active     : high in SPAWN and WAIT
//   game_over  : high in OVER only
//   state_dbg  : current FSM state (0 IDLE, 1 SPAWN, 2 WAIT, 3 OVER)
//
// Handshake: there is no valid/ready pair here. start is a level sampled on
// every rising edge and hit_reg is a per-cycle strobe; both are acted on in
// the cycle they are seen and need no acknowledgement.
// -----------------------------------------------------------------------------
module mole_spawner #(
  parameter int TICK_DIV   = 50000000,
  parameter int MOLE_LIFE  = 3,
  parameter int MAX_MISSES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] hit_reg,
  output logic [17:0] moles,
  output logic [3:0]  misses,
  output logic [7:0]  round_cnt,
  output logic        active,
  output logic        game_over,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPAWN = 2'd1,
    S_WAIT  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]    LIFE_LAST = 4'(MOLE_LIFE - 1);
  localparam logic [3:0]    MISS_END  = 4'(MAX_MISSES);
  localparam logic [17:0]   LFSR_SEED = 18'h2A5C3;

  state_t        state_q, state_d;
  logic [17:0]   lfsr_q, lfsr_d;
  logic [17:0]   moles_q, moles_d;
  logic [3:0]    misses_q, misses_d;
  logic [7:0]    round_q, round_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    life_q, life_d;
  logic          active_q, active_d;
  logic          over_q, over_d;

  // Reduce a 5-bit value (0..31) to a position 0..17 with one subtraction.
  function automatic logic [4:0] mod18(input logic [4:0] v);
    return (v >= 5'd18) ? (v - 5'd18) : v;
  endfunction

  function automatic logic [4:0] popcount18(input logic [17:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 18; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  logic [17:0] remaining;
  logic [17:0] spawn_pat;
  logic        tick;
  logic [4:0]  miss_pop;
  logic [5:0]  miss_sum;
  logic [3:0]  miss_sat;

  always_comb begin
    remaining = moles_q & ~hit_reg;
    tick      = (tick_cnt_q == TICK_LAST);
    // Second mole only when the LFSR MSB is set; idx_a == idx_b collapses to one.
    spawn_pat = (18'd1 << mod18(lfsr_q[4:0]))
              | (lfsr_q[17] ? (18'd1 << mod18(lfsr_q[9:5])) : 18'd0);
    // Misses after a hit has already cleared its position, so a same-cycle
    // hit wins over expiry.
    miss_pop  = popcount18(remaining);
    miss_sum  = {2'b00, misses_q} + {1'b0, miss_pop};
    miss_sat  = (miss_sum > 6'd15) ? 4'hF : miss_sum[3:0];
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = {lfsr_q[16:0], lfsr_q[17] ^ lfsr_q[10]};
    moles_d    = moles_q;
    misses_d   = misses_q;
    round_d    = round_q;
    tick_cnt_d = '0;
    life_d     = life_q;

    case (state_q)
      S_IDLE: begin
        moles_d = '0;
        if (start) begin
          state_d  = S_SPAWN;
          misses_d = '0;
          round_d  = '0;
        end
      end
      S_SPAWN: begin
        moles_d    = spawn_pat;
        tick_cnt_d = '0;
        life_d     = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        tick_cnt_d = tick ? '0 : (tick_cnt_q + 1'b1);
        moles_d    = remaining;
        // Early clear takes priority over an expiry in the same cycle.
        if (remaining == 18'd0) begin
          round_d = round_q + 8'd1;
          state_d = S_SPAWN;
        end else if (tick && (life_q == LIFE_LAST)) begin
          misses_d = miss_sat;
          moles_d  = '0;
          round_d  = round_q + 8'd1;
          state_d  = (miss_sat >= MISS_END) ? S_OVER : S_SPAWN;
        end else if (tick) begin
          life_d = life_q + 4'd1;
        end
      end
      S_OVER: begin
        moles_d = '0;
        if (start) begin
          state_d  = S_SPAWN;
          misses_d = '0;
          round_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    active_d = (state_d == S_SPAWN) || (state_d == S_WAIT);
    over_d   = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      moles_q    <= '0;
      misses_q   <= '0;
      round_q    <= '0;
      tick_cnt_q <= '0;
      life_q     <= '0;
      active_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      moles_q    <= moles_d;
      misses_q   <= misses_d;
      round_q    <= round_d;
      tick_cnt_q <= tick_cnt_d;
      life_q     <= life_d;
      active_q   <= active_d;
      over_q     <= over_d;
    end
  end

  assign moles     = moles_q;
  assign misses    = misses_q;
  assign round_cnt = round_q;
  assign active    = active_q;
  assign game_over = over_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mole_spawner.sv
// -----------------------------------------------------------------------------
// tb_mole_spawner
//
// Directed bench for mole_spawner with TICK_DIV=4, MOLE_LIFE=2, MAX_MISSES=3,
// so a round without hits expires after 8 WAIT cycles. Inputs are driven and
// outputs sampled on the falling edge. Expected mole patterns come from a
// small LFSR model that runs alongside the design from the same seed.
// -----------------------------------------------------------------------------
module tb_mole_spawner;
  localparam int TICK_DIV   = 4;
  localparam int MOLE_LIFE  = 2;
  localparam int MAX_MISSES = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SPAWN = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] hit_reg;
  logic [17:0] moles;
  logic [3:0]  misses;
  logic [7:0]  round_cnt;
  logic        active;
  logic        game_over;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  mole_spawner #(
    .TICK_DIV  (TICK_DIV),
    .MOLE_LIFE (MOLE_LIFE),
    .MAX_MISSES(MAX_MISSES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hit_reg  (hit_reg),
    .moles    (moles),
    .misses   (misses),
    .round_cnt(round_cnt),
    .active   (active),
    .game_over(game_over),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] m_lfsr;
  logic [17:0] exp_moles;
  logic [17:0] first_moles;
  logic [3:0]  exp_misses;
  logic [7:0]  exp_round;

  // Reference LFSR: x^18 + x^11 + 1, shifting every cycle from the seed.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 18'h2A5C3;
    else     m_lfsr <= {m_lfsr[16:0], m_lfsr[17] ^ m_lfsr[10]};
  end

  function automatic logic [17:0] pattern(input logic [17:0] l);
    int a, b;
    logic [17:0] p;
    a = int'(l[4:0]) % 18;
    b = int'(l[9:5]) % 18;
    p = 18'd1 << a;
    if (l[17]) p = p | (18'd1 << b);
    return p;
  endfunction

  function automatic int pop18(input logic [17:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 18; i++) if (v[i]) c++;
    return c;
  endfunction

  // driver: one-cycle start pulse; returns at the falling edge inside SPAWN
  // with exp_moles holding the pattern that SPAWN will raise.
  task automatic begin_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_moles = pattern(m_lfsr);
  endtask

  // driver: run an unhit round from SPAWN to the cycle after expiry
  task automatic run_unhit_round();
    exp_moles = pattern(m_lfsr);
    @(negedge clk);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hit_reg = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (moles !== 18'd0) begin n_fail++; $display("FAIL reset_moles: got %h expected %h", moles, 18'd0); end
    n_checks++; if (misses !== 4'd0) begin n_fail++; $display("FAIL reset_misses: got %0d expected 0", misses); end
    n_checks++; if (round_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_round: got %0d expected 0", round_cnt); end
    n_checks++; if (active !== 1'b0 || game_over !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got active=%b game_over=%b expected 0 0", active, game_over); end
    n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (state_dbg !== ST_IDLE || moles !== 18'd0) begin n_fail++; $display("FAIL idle_hold: got state=%0d moles=%h expected state=0 moles=0", state_dbg, moles); end
  endtask

  task automatic test_start();
    begin_game();
    n_checks++; if (state_dbg !== ST_SPAWN || active !== 1'b1) begin n_fail++; $display("FAIL start_spawn: got state=%0d active=%b expected state=1 active=1", state_dbg, active); end
    first_moles = exp_moles;
    @(negedge clk);
    n_checks++; if (state_dbg !== ST_WAIT) begin n_fail++; $display("FAIL start_wait: got %0d expected %0d", state_dbg, ST_WAIT); end
    n_checks++; if (moles !== exp_moles) begin n_fail++; $display("FAIL first_moles: got %h expected %h", moles, exp_moles); end
    n_checks++; if (pop18(moles) < 1 || pop18(moles) > 2) begin n_fail++; $display("FAIL mole_count: got %0d expected 1 or 2", pop18(moles)); end
    n_checks++; if (misses !== 4'd0 || active !== 1'b1) begin n_fail++; $display("FAIL start_status: got misses=%0d active=%b expected 0 1", misses, active); end
    // start while playing has no effect
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (state_dbg !== ST_WAIT || round_cnt !== 8'd0 || moles !== exp_moles) begin n_fail++; $display("FAIL start_ignored: got state=%0d round=%0d moles=%h expected state=2 round=0 moles=%h", state_dbg, round_cnt, moles, exp_moles); end
    exp_misses = 4'd0;
    exp_round  = 8'd0;
  endtask

  task automatic test_hit_clear();
    hit_reg = exp_moles;
    @(negedge clk);
    hit_reg = '0;
    exp_round = exp_round + 8'd1;
    n_checks++; if (moles !== 18'd0 || round_cnt !== exp_round) begin n_fail++; $display("FAIL hit_clear: got moles=%h round=%0d expected moles=0 round=%0d", moles, round_cnt, exp_round); end
    n_checks++; if (state_dbg !== ST_SPAWN) begin n_fail++; $display("FAIL hit_respawn: got %0d expected %0d", state_dbg, ST_SPAWN); end
    exp_moles = pattern(m_lfsr);
    @(negedge clk);
    n_checks++; if (moles !== exp_moles) begin n_fail++; $display("FAIL second_moles: got %h expected %h", moles, exp_moles); end
  endtask

  task automatic test_expiry();
    repeat (7) @(negedge clk);
    n_checks++; if (state_dbg !== ST_WAIT || moles !== exp_moles) begin n_fail++; $display("FAIL pre_expiry: got state=%0d moles=%h expected state=2 moles=%h", state_dbg, moles, exp_moles); end
    @(negedge clk);
    exp_misses = exp_misses + 4'(pop18(exp_moles));
    exp_round  = exp_round + 8'd1;
    n_checks++; if (misses !== exp_misses) begin n_fail++; $display("FAIL expiry_misses: got %0d expected %0d", misses, exp_misses); end
    n_checks++; if (moles !== 18'd0 || round_cnt !== exp_round) begin n_fail++; $display("FAIL expiry_clear: got moles=%h round=%0d expected moles=0 round=%0d", moles, round_cnt, exp_round); end
    n_checks++; if (state_dbg !== ST_SPAWN) begin n_fail++; $display("FAIL expiry_state: got %0d expected %0d", state_dbg, ST_SPAWN); end
  endtask

  task automatic test_game_over();
    bit done;
    int sum;
    done = 1'b0;
    for (int r = 0; r < 6 && !done; r++) begin
      run_unhit_round();
      sum = int'(exp_misses) + pop18(exp_moles);
      exp_misses = (sum > 15) ? 4'd15 : 4'(sum);
      exp_round  = exp_round + 8'd1;
      if (int'(exp_misses) >= MAX_MISSES) done = 1'b1;
      n_checks++; if (misses !== exp_misses || round_cnt !== exp_round) begin n_fail++; $display("FAIL over_round%0d: got misses=%0d round=%0d expected %0d %0d", r, misses, round_cnt, exp_misses, exp_round); end
      n_checks++; if (state_dbg !== (done ? ST_OVER : ST_SPAWN)) begin n_fail++; $display("FAIL over_state%0d: got %0d expected %0d", r, state_dbg, done ? ST_OVER : ST_SPAWN); end
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL over_reached: got misses=%0d expected >= %0d", misses, MAX_MISSES); end
    n_checks++; if (game_over !== 1'b1 || active !== 1'b0 || moles !== 18'd0) begin n_fail++; $display("FAIL over_outputs: got go=%b act=%b moles=%h expected 1 0 0", game_over, active, moles); end
    repeat (3) @(negedge clk);
    n_checks++; if (state_dbg !== ST_OVER || misses !== exp_misses || round_cnt !== exp_round) begin n_fail++; $display("FAIL over_hold: got state=%0d misses=%0d round=%0d expected 3 %0d %0d", state_dbg, misses, round_cnt, exp_misses, exp_round); end
    begin_game();
    exp_misses = 4'd0;
    exp_round  = 8'd0;
    n_checks++; if (state_dbg !== ST_SPAWN || misses !== 4'd0 || round_cnt !== 8'd0 || game_over !== 1'b0) begin n_fail++; $display("FAIL restart: got state=%0d misses=%0d round=%0d go=%b expected 1 0 0 0", state_dbg, misses, round_cnt, game_over); end
  endtask

  task automatic test_hit_on_expiry();
    bit found;
    logic [17:0] nm, one;
    found = 1'b0;
    for (int r = 0; r < 40 && !found; r++) begin
      exp_moles = pattern(m_lfsr);
      @(negedge clk);
      if (pop18(exp_moles) == 2) found = 1'b1;
      else begin
        hit_reg = exp_moles;
        @(negedge clk);
        hit_reg = '0;
        exp_round = exp_round + 8'd1;
      end
    end
    n_checks++; if (!found || moles !== exp_moles) begin n_fail++; $display("FAIL two_moles: got %h expected two-mole %h", moles, exp_moles); end
    nm = '0; one = '0;
    for (int i = 17; i >= 0; i--) begin
      if (!exp_moles[i]) nm = 18'd1 << i;
      else one = 18'd1 << i;
    end
    hit_reg = nm;
    @(negedge clk);
    hit_reg = '0;
    n_checks++; if (moles !== exp_moles) begin n_fail++; $display("FAIL nonmole_hit: got %h expected %h", moles, exp_moles); end
    repeat (6) @(negedge clk);
    hit_reg = one;
    @(negedge clk);
    hit_reg = '0;
    exp_misses = exp_misses + 4'd1;
    exp_round  = exp_round + 8'd1;
    n_checks++; if (misses !== exp_misses || moles !== 18'd0) begin n_fail++; $display("FAIL hit_wins: got misses=%0d moles=%h expected %0d 0", misses, moles, exp_misses); end
    n_checks++; if (round_cnt !== exp_round || state_dbg !== ST_SPAWN) begin n_fail++; $display("FAIL hit_wins_round: got round=%0d state=%0d expected %0d 1", round_cnt, state_dbg, exp_round); end
  endtask

  task automatic test_back_to_back();
    exp_moles = pattern(m_lfsr);
    @(negedge clk);
    repeat (7) @(negedge clk);
    hit_reg = exp_moles;
    @(negedge clk);
    hit_reg = '0;
    exp_round = exp_round + 8'd1;
    n_checks++; if (misses !== exp_misses || round_cnt !== exp_round) begin n_fail++; $display("FAIL clear_at_expiry: got misses=%0d round=%0d expected %0d %0d", misses, round_cnt, exp_misses, exp_round); end
    n_checks++; if (state_dbg !== ST_SPAWN || moles !== 18'd0) begin n_fail++; $display("FAIL clear_at_expiry_state: got state=%0d moles=%h expected 1 0", state_dbg, moles); end
    exp_moles = pattern(m_lfsr);
    @(negedge clk);
    n_checks++; if (moles !== exp_moles || state_dbg !== ST_WAIT) begin n_fail++; $display("FAIL b2b_spawn: got moles=%h state=%0d expected %h 2", moles, state_dbg, exp_moles); end
  endtask

  task automatic test_reset_mid_wait();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (moles !== 18'd0 || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL async_reset: got moles=%h state=%0d expected 0 0", moles, state_dbg); end
    n_checks++; if (misses !== 4'd0 || round_cnt !== 8'd0 || active !== 1'b0) begin n_fail++; $display("FAIL async_reset_cnt: got misses=%0d round=%0d active=%b expected 0 0 0", misses, round_cnt, active); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    begin_game();
    n_checks++; if (exp_moles !== first_moles) begin n_fail++; $display("FAIL lfsr_restart_model: got %h expected %h", exp_moles, first_moles); end
    @(negedge clk);
    n_checks++; if (moles !== first_moles) begin n_fail++; $display("FAIL lfsr_restart: got %h expected %h", moles, first_moles); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_clear();
    test_expiry();
    test_game_over();
    test_hit_on_expiry();
    test_back_to_back();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_spawner.md
MOLE_SPAWNER -- requirements
Module: mole_spawner

Interface
REQ-001 Parameter TICK_DIV, default 50000000, meaning clk cycles per game tick (1 s at 50 MHz); legal range 2 or more.
REQ-002 Parameter MOLE_LIFE, default 3, meaning ticks a round's moles stay up; legal range 1..15.
REQ-003 Parameter MAX_MISSES, default 5, meaning missed-mole count that ends the game; legal range 1..15.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  level-sampled each clk; begins a game from IDLE or OVER.
REQ-007 hit_reg  input  18  one bit per mole position; 1 = that position was hit this cycle.
REQ-008 moles  output  18  currently raised moles; drives the whack logic's mole input.
REQ-009 misses  output  4  moles that expired unhit this game, saturating.
REQ-010 round_cnt  output  8  completed rounds this game, wraps 255 -> 0.
REQ-011 active  output  1  high in SPAWN and WAIT.
REQ-012 game_over  output  1  high in OVER only.

Function
REQ-013 The FSM SHALL have states IDLE, SPAWN, WAIT, OVER, with all outputs registered.
REQ-014 The 18-bit LFSR SHALL use taps x^18+x^11+1, shift every clk in every state, and never reach zero.
REQ-015 idx_a and idx_b SHALL be derived from lfsr[4:0] and lfsr[9:5] respectively, as value mod 18 computed as value minus 18 when value is 18 or more.
REQ-016 IDLE: moles=0; start=1 -> SPAWN.
REQ-017 SPAWN lasts one cycle: moles <= onehot(idx_a) | (lfsr[17] ? onehot(idx_b) : 0); tick counter and life counter cleared; -> WAIT.
REQ-018 Tick counter SHALL run 0..TICK_DIV-1 in WAIT only and emit a one-cycle tick when value = TICK_DIV-1, then return to 0.
REQ-019 WAIT, every cycle: moles <= moles & ~hit_reg; hit_reg bits on positions without a raised mole are ignored.
REQ-020 WAIT, when (moles & ~hit_reg) == 0: round_cnt+1, -> SPAWN next cycle (early clear, no misses).
REQ-021 WAIT, tick with life counter = MOLE_LIFE-1: misses += popcount(moles & ~hit_reg), saturating at 15; moles <= 0; round_cnt+1.
REQ-022 In the REQ-021 case, the FSM SHALL go to OVER if updated misses >= MAX_MISSES, else to SPAWN.
REQ-023 WAIT, tick otherwise: life counter +1.
REQ-024 A hit arriving in the same cycle as expiry SHALL win: that position is cleared and not counted as a miss.
REQ-025 When REQ-020 and REQ-021 apply in the same cycle, the REQ-020 path SHALL be taken.
REQ-026 start SHALL be ignored in SPAWN and WAIT.
REQ-027 OVER: moles=0, game_over=1, misses and round_cnt held; start=1 -> SPAWN with misses=0 and round_cnt=0.
REQ-028 popcount SHALL be evaluated over 18 bits at 5-bit width before the saturating add.

Reset
REQ-029 On rst=1, regardless of clk: state=IDLE, moles=0, misses=0, round_cnt=0, active=0, game_over=0, counters=0, lfsr=18'h2A5C3.
REQ-030 Reset asserted mid-round SHALL discard the round with no miss or round credit.
REQ-031 After rst deasserts, first state change SHALL occur on the first clk edge with start=1.

Verification (TICK_DIV=4, MOLE_LIFE=2, MAX_MISSES=3)
REQ-032 Reset then 1-cycle start -> one cycle SPAWN, then moles nonzero with popcount 1 or 2, active=1, misses=0.
REQ-033 In WAIT, drive hit_reg=moles for 1 cycle -> next cycle moles=0, round_cnt=1, then a new SPAWN.
REQ-034 No hits -> expiry after 8 WAIT cycles; misses = mole popcount; moles=0; round_cnt=1.
REQ-035 Repeat unhit rounds until misses >= 3 -> OVER, game_over=1, active=0, moles=0; start then restarts with misses=0 and round_cnt=0.
REQ-036 Hit one of two moles in the expiry cycle -> misses +1 only; hit_reg on a non-mole bit -> no change to moles.
REQ-037 Assert rst mid-WAIT with moles=18'h00101 -> moles=0, IDLE, misses=0 immediately without a clk edge; LFSR restarts from 18'h2A5C3.
